// File: rtl/fetch_unit_if.sv
// Bundle between the fetch stage, instruction memory, branch predictor, execute redirect and decode.
// Handshake: decode takes the head entry on a rising clock edge exactly when if_valid and if_ready are both
// high in that cycle. if_valid never depends on if_ready. Fields are stable while if_valid is high and not taken.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        bp_taken;
  logic [31:0] bp_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        fetch_fault;
  logic [31:0] fetch_fault_pc;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  bp_taken,
    input  bp_target,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc,
    output if_pred_taken,
    output if_pred_target,
    output fetch_fault,
    output fetch_fault_pc
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output bp_taken,
    output bp_target,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc,
    input  if_pred_taken,
    input  if_pred_target,
    input  fetch_fault,
    input  fetch_fault_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, reads imem/predictor combinationally, buffers entries in a small FIFO for decode.
// Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned PC traps into FAULT instead of being forced aligned.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic       clk,
  input  logic       rst,
  fetch_unit_if.master bus,
  output logic [1:0] state_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  function automatic logic [31:0] load_pc(input logic [31:0] p);
`ifdef FETCH_MISALIGN_TRAP_EN
    return p;
`else
    return {p[31:2], 2'b00};
`endif
  endfunction

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] mem_pc_q     [DEPTH];
  logic [31:0] mem_instr_q  [DEPTH];
  logic        mem_taken_q  [DEPTH];
  logic [31:0] mem_target_q [DEPTH];

  logic not_empty;
  logic room;
  logic deq;
  logic fetch;
  logic misaligned;

  assign not_empty = (count_q != '0);
  assign deq       = bus.if_valid & bus.if_ready;
  assign room      = (count_q < CNT_W'(DEPTH)) | deq;
  assign fetch     = (state_q == ST_RUN) & room & ~bus.redirect_valid & ~misaligned;

  assign bus.imem_addr      = pc_q;
  assign bus.if_valid       = not_empty & ~bus.redirect_valid;
  assign bus.if_instr       = not_empty ? mem_instr_q[rd_ptr_q]  : NOP_INSTR;
  assign bus.if_pc          = not_empty ? mem_pc_q[rd_ptr_q]     : 32'h0;
  assign bus.if_pred_taken  = not_empty ? mem_taken_q[rd_ptr_q]  : 1'b0;
  assign bus.if_pred_target = not_empty ? mem_target_q[rd_ptr_q] : 32'h0;
  assign state_o            = state_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.redirect_valid) begin
      // Flush wins over everything, including a same-cycle dequeue.
      state_d  = ST_RUN;
      pc_d     = load_pc(bus.redirect_pc);
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (deq) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (fetch) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        pc_d     = bus.bp_taken ? load_pc(bus.bp_target) : pc_q + 32'd4;
      end
      count_d = count_q + CNT_W'(fetch) - CNT_W'(deq);
      case (state_q)
        ST_BOOT:  state_d = ST_RUN;
        ST_RUN:   state_d = misaligned ? ST_FAULT : ST_RUN;
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      pc_q     <= load_pc(RESET_PC);
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head fields are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (fetch) begin
      mem_pc_q[wr_ptr_q]     <= pc_q;
      mem_instr_q[wr_ptr_q]  <= bus.imem_rdata;
      mem_taken_q[wr_ptr_q]  <= bus.bp_taken;
      mem_target_q[wr_ptr_q] <= bus.bp_target;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;

  assign misaligned = (pc_q[1:0] != 2'b00);

  always_comb begin
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    if (bus.redirect_valid) begin
      fault_d    = 1'b0;
      fault_pc_d = 32'h0;
    end else if ((state_q == ST_RUN) && misaligned) begin
      fault_d    = 1'b1;
      fault_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q    <= 1'b0;
      fault_pc_q <= 32'h0;
    end else begin
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign bus.fetch_fault    = fault_q;
  assign bus.fetch_fault_pc = fault_pc_q;
`else
  assign misaligned         = 1'b0;
  assign bus.fetch_fault    = 1'b0;
  assign bus.fetch_fault_pc = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scoreboard of expected {pc, instr, pred_taken, pred_target} checked on every dequeue.
module tb_fetch_unit;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          W     = 97;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.master),
    .state_o (state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  logic        bp_en;
  logic [31:0] bp_match;
  logic [31:0] bp_tgt;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  assign bus.imem_rdata = imem_word(bus.imem_addr);

  always_comb begin
    bus.bp_taken  = bp_en && (bus.imem_addr == bp_match);
    bus.bp_target = (bp_en && (bus.imem_addr == bp_match)) ? bp_tgt : 32'h0;
  end

  function automatic void push_exp(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    exp_q.push_back({pc, imem_word(pc), tk, tgt});
  endfunction

  // Scoreboard: every accepted head entry must match the front of the expected queue.
  always @(negedge clk) begin
    if (!rst && bus.if_valid && bus.if_ready) begin
      logic [W-1:0] got;
      logic [W-1:0] exp;
      got = {bus.if_pc, bus.if_instr, bus.if_pred_taken, bus.if_pred_target};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL deq_unexpected got pc=%h instr=%h required none", bus.if_pc, bus.if_instr);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          bad++;
          $display("FAIL deq_entry got pc=%h instr=%h tk=%b tgt=%h required pc=%h instr=%h tk=%b tgt=%h",
                   got[96:65], got[64:33], got[32], got[31:0], exp[96:65], exp[64:33], exp[32], exp[31:0]);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic flush(input logic [31:0] p);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = p;
    cycle();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      cycle();
    end
    if (exp_q.size() == 0) ok = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.if_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bp_en = 1'b0;
    bp_match = 32'h0;
    bp_tgt = 32'h0;
    repeat (2) @(negedge clk);
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL rst_imem_addr got %h required 0", bus.imem_addr); end
    total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL rst_if_valid got %b required 0", bus.if_valid); end
    total++; if (bus.if_instr !== NOP) begin bad++; $display("FAIL rst_if_instr got %h required %h", bus.if_instr, NOP); end
    total++; if (bus.if_pc !== 32'h0) begin bad++; $display("FAIL rst_if_pc got %h required 0", bus.if_pc); end
    total++; if (bus.if_pred_taken !== 1'b0) begin bad++; $display("FAIL rst_pred_taken got %b required 0", bus.if_pred_taken); end
    total++; if (bus.if_pred_target !== 32'h0) begin bad++; $display("FAIL rst_pred_target got %h required 0", bus.if_pred_target); end
    total++; if (bus.fetch_fault !== 1'b0) begin bad++; $display("FAIL rst_fetch_fault got %b required 0", bus.fetch_fault); end
    total++; if (bus.fetch_fault_pc !== 32'h0) begin bad++; $display("FAIL rst_fault_pc got %h required 0", bus.fetch_fault_pc); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL rst_state got %0d required 0", state); end
  endtask

  task automatic test_stream();
    bit ok;
    for (int i = 0; i < 8; i++) push_exp(32'(4 * i), 1'b0, 32'h0);
    cycle();
    rst = 1'b0;
    bus.if_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL boot_valid_c0 got %b required 0", bus.if_valid); end
    @(negedge clk);
    total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL boot_valid_c1 got %b required 0", bus.if_valid); end
    @(negedge clk);
    total++; if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL boot_valid_c2 got %b required 1", bus.if_valid); end
    @(posedge clk);
    #1;
    wait_drain(40, ok);
    total++; if (!ok) begin bad++; $display("FAIL stream_drain got %0d left required 0", exp_q.size()); exp_q.delete(); end
    bus.if_ready = 1'b0;
    flush(32'h0);
  endtask

  task automatic test_backpressure();
    bit ok;
    repeat (3) cycle();
    rst = 1'b1;
    #1;
    total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got %b required 0", bus.if_valid); end
    total++; if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL midrst_addr got %h required 0", bus.imem_addr); end
    cycle();
    rst = 1'b0;
    repeat (5) cycle();
    @(negedge clk);
    total++; if (bus.imem_addr !== 32'(4 * DEPTH)) begin bad++; $display("FAIL full_addr got %h required %h", bus.imem_addr, 32'(4 * DEPTH)); end
    total++; if (bus.if_valid !== 1'b1) begin bad++; $display("FAIL full_valid got %b required 1", bus.if_valid); end
    repeat (2) cycle();
    @(negedge clk);
    total++; if (bus.imem_addr !== 32'(4 * DEPTH)) begin bad++; $display("FAIL full_hold got %h required %h", bus.imem_addr, 32'(4 * DEPTH)); end
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) push_exp(32'(4 * i), 1'b0, 32'h0);
    bus.if_ready = 1'b1;
    wait_drain(40, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_drain got %0d left required 0", exp_q.size()); exp_q.delete(); end
    bus.if_ready = 1'b0;
    flush(32'h0);
  endtask

  task automatic test_predict();
    bit ok;
    bp_en = 1'b1;
    bp_match = 32'h8;
    bp_tgt = 32'h100;
    push_exp(32'h0, 1'b0, 32'h0);
    push_exp(32'h4, 1'b0, 32'h0);
    push_exp(32'h8, 1'b1, 32'h100);
    push_exp(32'h100, 1'b0, 32'h0);
    push_exp(32'h104, 1'b0, 32'h0);
    bus.if_ready = 1'b1;
    flush(32'h0);
    wait_drain(30, ok);
    total++; if (!ok) begin bad++; $display("FAIL pred_drain got %0d left required 0", exp_q.size()); exp_q.delete(); end
    bus.if_ready = 1'b0;
    bp_en = 1'b0;
    flush(32'h0);
  endtask

  task automatic test_redirect_full();
    bit ok;
    repeat (4) cycle();
    bus.if_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h200;
    push_exp(32'h200, 1'b0, 32'h0);
    push_exp(32'h204, 1'b0, 32'h0);
    push_exp(32'h208, 1'b0, 32'h0);
    @(negedge clk);
    total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL redir_valid got %b required 0", bus.if_valid); end
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    wait_drain(30, ok);
    total++; if (!ok) begin bad++; $display("FAIL redir_drain got %0d left required 0", exp_q.size()); exp_q.delete(); end
    bus.if_ready = 1'b0;
    flush(32'h0);
  endtask

  task automatic test_wrap();
    bit ok;
    push_exp(32'hFFFF_FFF8, 1'b0, 32'h0);
    push_exp(32'hFFFF_FFFC, 1'b0, 32'h0);
    push_exp(32'h0000_0000, 1'b0, 32'h0);
    push_exp(32'h0000_0004, 1'b0, 32'h0);
    bus.if_ready = 1'b1;
    flush(32'hFFFF_FFF8);
    wait_drain(30, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_drain got %0d left required 0", exp_q.size()); exp_q.delete(); end
    bus.if_ready = 1'b0;
    flush(32'h0);
  endtask

  task automatic test_misalign();
    bit ok;
    bus.if_ready = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
    flush(32'h202);
    cycle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (bus.fetch_fault !== 1'b1) begin bad++; $display("FAIL mis_fault got %b required 1", bus.fetch_fault); end
      total++; if (bus.fetch_fault_pc !== 32'h202) begin bad++; $display("FAIL mis_fault_pc got %h required 202", bus.fetch_fault_pc); end
      total++; if (bus.if_valid !== 1'b0) begin bad++; $display("FAIL mis_valid got %b required 0", bus.if_valid); end
      @(posedge clk);
      #1;
    end
    push_exp(32'h300, 1'b0, 32'h0);
    push_exp(32'h304, 1'b0, 32'h0);
    flush(32'h300);
    @(negedge clk);
    total++; if (bus.fetch_fault !== 1'b0) begin bad++; $display("FAIL mis_clear got %b required 0", bus.fetch_fault); end
    total++; if (bus.fetch_fault_pc !== 32'h0) begin bad++; $display("FAIL mis_clear_pc got %h required 0", bus.fetch_fault_pc); end
    @(posedge clk);
    #1;
`else
    push_exp(32'h200, 1'b0, 32'h0);
    push_exp(32'h204, 1'b0, 32'h0);
    flush(32'h202);
    @(negedge clk);
    total++; if (bus.fetch_fault !== 1'b0) begin bad++; $display("FAIL mis_fault got %b required 0", bus.fetch_fault); end
    total++; if (bus.fetch_fault_pc !== 32'h0) begin bad++; $display("FAIL mis_fault_pc got %h required 0", bus.fetch_fault_pc); end
    @(posedge clk);
    #1;
`endif
    wait_drain(30, ok);
    total++; if (!ok) begin bad++; $display("FAIL mis_drain got %0d left required 0", exp_q.size()); exp_q.delete(); end
    bus.if_ready = 1'b0;
    flush(32'h0);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_predict();
    test_redirect_full();
    test_wrap();
    test_misalign();
    repeat (2) cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    bad++;
    $display("FAIL watchdog got timeout required completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
